// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle MIPS control FSM with memory-ready and multiplier
//               stalls; also decodes the ALU control field.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int MULT_CYCLES = 4,
    parameter bit BNE_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       link,
    output logic       mult,
    output logic       mult_busy,
    output logic       mfhi,
    output logic       mflo,
    output logic       illegal
);

    localparam logic [3:0] c_fetch   = 4'd0;
    localparam logic [3:0] c_decode  = 4'd1;
    localparam logic [3:0] c_memadr  = 4'd2;
    localparam logic [3:0] c_memrd   = 4'd3;
    localparam logic [3:0] c_memwb   = 4'd4;
    localparam logic [3:0] c_memwr   = 4'd5;
    localparam logic [3:0] c_rtypeex = 4'd6;
    localparam logic [3:0] c_rtypewb = 4'd7;
    localparam logic [3:0] c_branch  = 4'd8;
    localparam logic [3:0] c_addiex  = 4'd9;
    localparam logic [3:0] c_addiwb  = 4'd10;
    localparam logic [3:0] c_jump    = 4'd11;
    localparam logic [3:0] c_jal     = 4'd12;
    localparam logic [3:0] c_jr      = 4'd13;
    localparam logic [3:0] c_mult    = 4'd14;
    localparam logic [3:0] c_mfwb    = 4'd15;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    localparam logic [5:0] c_fn_add  = 6'b100000;
    localparam logic [5:0] c_fn_sub  = 6'b100010;
    localparam logic [5:0] c_fn_and  = 6'b100100;
    localparam logic [5:0] c_fn_or   = 6'b100101;
    localparam logic [5:0] c_fn_slt  = 6'b101010;
    localparam logic [5:0] c_fn_jr   = 6'b001000;
    localparam logic [5:0] c_fn_mult = 6'b011000;
    localparam logic [5:0] c_fn_mfhi = 6'b010000;
    localparam logic [5:0] c_fn_mflo = 6'b010010;

    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_slt = 3'b111;

    localparam int                  c_cnt_w     = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0]  c_mult_last = c_cnt_w'(MULT_CYCLES - 1);

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [c_cnt_w-1:0] r_mult_cnt;
    logic               w_mult_done;

    assign w_mult_done = (r_mult_cnt == c_mult_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter only runs while in MULT so every multiply starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mult_cnt <= '0;
        end else if (r_state == c_mult && !w_mult_done) begin
            r_mult_cnt <= r_mult_cnt + c_cnt_w'(1);
        end else begin
            r_mult_cnt <= '0;
        end
    end

    always_comb begin
        w_next     = c_fetch;
        mem_req    = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = c_alu_add;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        link       = 1'b0;
        mult       = 1'b0;
        mult_busy  = 1'b0;
        mfhi       = 1'b0;
        mflo       = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            c_fetch: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                w_next  = mem_ready ? c_decode : c_fetch;
            end
            c_decode: begin
                alusrcb = 2'b11;
                case (op)
                    c_op_lw, c_op_sw: w_next = c_memadr;
                    c_op_beq:         w_next = c_branch;
                    c_op_bne: begin
                        if (BNE_EN) w_next = c_branch;
                        else        illegal = 1'b1;
                    end
                    c_op_addi:        w_next = c_addiex;
                    c_op_j:           w_next = c_jump;
                    c_op_jal:         w_next = c_jal;
                    c_op_rtype: begin
                        case (funct)
                            c_fn_add, c_fn_sub, c_fn_and,
                            c_fn_or, c_fn_slt:       w_next = c_rtypeex;
                            c_fn_jr:                 w_next = c_jr;
                            c_fn_mult:               w_next = c_mult;
                            c_fn_mfhi, c_fn_mflo:    w_next = c_mfwb;
                            default:                 illegal = 1'b1;
                        endcase
                    end
                    default:          illegal = 1'b1;
                endcase
            end
            c_memadr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == c_op_sw) ? c_memwr : c_memrd;
            end
            c_memrd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                w_next  = mem_ready ? c_memwb : c_memrd;
            end
            c_memwb: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            c_memwr: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                w_next   = mem_ready ? c_fetch : c_memwr;
            end
            c_rtypeex: begin
                alusrca = 1'b1;
                case (funct)
                    c_fn_sub: alucontrol = c_alu_sub;
                    c_fn_and: alucontrol = c_alu_and;
                    c_fn_or:  alucontrol = c_alu_or;
                    c_fn_slt: alucontrol = c_alu_slt;
                    default:  alucontrol = c_alu_add;
                endcase
                w_next = c_rtypewb;
            end
            c_rtypewb: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            c_branch: begin
                alusrca    = 1'b1;
                alucontrol = c_alu_sub;
                pcsrc      = 2'b01;
                pcwrite    = (op == c_op_bne) ? ~zero : zero;
            end
            c_addiex: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = c_addiwb;
            end
            c_addiwb: regwrite = 1'b1;
            c_jump: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            c_jal: begin
                pcwrite  = 1'b1;
                pcsrc    = 2'b10;
                regwrite = 1'b1;
                link     = 1'b1;
            end
            c_jr: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b11;
            end
            c_mult: begin
                mult      = (r_mult_cnt == '0);
                mult_busy = 1'b1;
                w_next    = w_mult_done ? c_fetch : c_mult;
            end
            c_mfwb: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                mfhi     = (funct == c_fn_mfhi);
                mflo     = (funct == c_fn_mflo);
            end
            default: w_next = c_fetch;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluc;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       link;
        logic       mult;
        logic       busy;
        logic       mfhi;
        logic       mflo;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       r_reset;
    logic [5:0] r_op;
    logic [5:0] r_funct;
    logic       r_zero;
    logic       r_mem_ready;
    wire [21:0] w_act;
    wire [21:0] w_nb;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

`define CTL_PORTS(v) \
        .mem_req(v[21]), .iord(v[20]), .irwrite(v[19]), .memwrite(v[18]), \
        .pcwrite(v[17]), .pcsrc(v[16:15]), .alusrca(v[14]), .alusrcb(v[13:12]), \
        .alucontrol(v[11:9]), .regwrite(v[8]), .regdst(v[7]), .memtoreg(v[6]), \
        .link(v[5]), .mult(v[4]), .mult_busy(v[3]), .mfhi(v[2]), .mflo(v[1]), \
        .illegal(v[0])

    multicycle_controller #(.MULT_CYCLES(4), .BNE_EN(1'b1)) dut (
        .clk(clk), .reset(r_reset), .op(r_op), .funct(r_funct),
        .zero(r_zero), .mem_ready(r_mem_ready),
        `CTL_PORTS(w_act)
    );

    multicycle_controller #(.MULT_CYCLES(4), .BNE_EN(1'b0)) dut_nb (
        .clk(clk), .reset(r_reset), .op(r_op), .funct(r_funct),
        .zero(r_zero), .mem_ready(r_mem_ready),
        `CTL_PORTS(w_nb)
    );

`undef CTL_PORTS

    function automatic ctl_t e_base();
        ctl_t e;
        e      = '0;
        e.aluc = 3'b010;
        return e;
    endfunction

    function automatic ctl_t e_fetch(input logic rdy);
        ctl_t e = e_base();
        e.mem_req = 1'b1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy;
        return e;
    endfunction

    function automatic ctl_t e_decode(input logic ill);
        ctl_t e = e_base();
        e.alusrcb = 2'b11; e.illegal = ill;
        return e;
    endfunction

    function automatic ctl_t e_memadr();
        ctl_t e = e_base();
        e.alusrca = 1'b1; e.alusrcb = 2'b10;
        return e;
    endfunction

    function automatic ctl_t e_mem(input logic wr);
        ctl_t e = e_base();
        e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = wr;
        return e;
    endfunction

    function automatic ctl_t e_wb(input logic dst, input logic m2r);
        ctl_t e = e_base();
        e.regwrite = 1'b1; e.regdst = dst; e.memtoreg = m2r;
        return e;
    endfunction

    function automatic ctl_t e_rex(input logic [2:0] aluc);
        ctl_t e = e_base();
        e.alusrca = 1'b1; e.aluc = aluc;
        return e;
    endfunction

    function automatic ctl_t e_br(input logic pcw);
        ctl_t e = e_base();
        e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcwrite = pcw;
        return e;
    endfunction

    function automatic ctl_t e_jmp(input logic [1:0] src, input logic lnk);
        ctl_t e = e_base();
        e.pcwrite = 1'b1; e.pcsrc = src; e.regwrite = lnk; e.link = lnk;
        return e;
    endfunction

    function automatic ctl_t e_mult(input logic first);
        ctl_t e = e_base();
        e.mult = first; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ctl_t e_mfwb(input logic hi);
        ctl_t e = e_base();
        e.regwrite = 1'b1; e.regdst = 1'b1; e.mfhi = hi; e.mflo = ~hi;
        return e;
    endfunction

    task automatic check(input string tag, input ctl_t act, input ctl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; inputs are already settled for this cycle.
    task automatic step(input string tag, input ctl_t exp);
        #1;
        check(tag, w_act, exp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        r_reset = 1'b1;
        #1;
        check("reset", w_act, e_fetch(r_mem_ready));
        @(negedge clk);
        r_reset = 1'b0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        r_op = op; r_funct = fn; r_zero = z;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] fn_tab   [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] alu_tab  [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [5:0] br_op    [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        logic       br_z     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       br_taken [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        r_reset = 1'b1; r_mem_ready = 1'b1;
        set_instr(6'b000000, 6'b100000, 1'b0);
        @(negedge clk);

        // R-type ALU ops, add first
        for (int i = 0; i < 5; i++) begin
            set_instr(6'b000000, fn_tab[i], 1'b0);
            do_reset();
            step("rt_fetch", e_fetch(1'b1));
            step("rt_decode", e_decode(1'b0));
            step("rt_ex", e_rex(alu_tab[i]));
            step("rt_wb", e_wb(1'b1, 1'b0));
            step("rt_back", e_fetch(1'b1));
        end

        // lw with fetch stall and three memory stall cycles
        set_instr(6'b100011, 6'b000000, 1'b0);
        r_mem_ready = 1'b0;
        do_reset();
        step("lw_fetch_stall", e_fetch(1'b0));
        r_mem_ready = 1'b1;
        step("lw_fetch", e_fetch(1'b1));
        step("lw_decode", e_decode(1'b0));
        step("lw_memadr", e_memadr());
        r_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_memrd_stall", e_mem(1'b0));
        r_mem_ready = 1'b1;
        step("lw_memrd", e_mem(1'b0));
        step("lw_memwb", e_wb(1'b0, 1'b1));
        step("lw_back", e_fetch(1'b1));

        // beq/bne with both zero values; second instance has bne disabled
        for (int i = 0; i < 4; i++) begin
            set_instr(br_op[i], 6'b000000, br_z[i]);
            do_reset();
            step("br_fetch", e_fetch(1'b1));
            #1;
            check("br_decode", w_act, e_decode(1'b0));
            check("br_nb_decode", w_nb, e_decode(br_op[i] == 6'b000101));
            @(negedge clk);
            #1;
            check("br_exec", w_act, e_br(br_taken[i]));
            check("br_nb_next", w_nb, (br_op[i] == 6'b000101) ? e_fetch(1'b1) : e_br(br_taken[i]));
            @(negedge clk);
            step("br_back", e_fetch(1'b1));
        end

        // mult aborted by reset, then a full multiply
        set_instr(6'b000000, 6'b011000, 1'b0);
        do_reset();
        step("mu_fetch", e_fetch(1'b1));
        step("mu_decode", e_decode(1'b0));
        step("mu_first", e_mult(1'b1));
        step("mu_busy", e_mult(1'b0));
        do_reset();
        step("mu_fetch2", e_fetch(1'b1));
        step("mu_decode2", e_decode(1'b0));
        step("mu_first2", e_mult(1'b1));
        for (int i = 0; i < 3; i++) step("mu_busy2", e_mult(1'b0));
        step("mu_back", e_fetch(1'b1));

        // jal, j, jr
        set_instr(6'b000011, 6'b000000, 1'b0);
        do_reset();
        step("jal_fetch", e_fetch(1'b1));
        step("jal_decode", e_decode(1'b0));
        step("jal_exec", e_jmp(2'b10, 1'b1));
        step("jal_back", e_fetch(1'b1));
        set_instr(6'b000010, 6'b000000, 1'b0);
        do_reset();
        step("j_fetch", e_fetch(1'b1));
        step("j_decode", e_decode(1'b0));
        step("j_exec", e_jmp(2'b10, 1'b0));
        set_instr(6'b000000, 6'b001000, 1'b0);
        do_reset();
        step("jr_fetch", e_fetch(1'b1));
        step("jr_decode", e_decode(1'b0));
        step("jr_exec", e_jmp(2'b11, 1'b0));
        step("jr_back", e_fetch(1'b1));

        // addi
        set_instr(6'b001000, 6'b000000, 1'b0);
        do_reset();
        step("addi_fetch", e_fetch(1'b1));
        step("addi_decode", e_decode(1'b0));
        step("addi_ex", e_memadr());
        step("addi_wb", e_wb(1'b0, 1'b0));
        step("addi_back", e_fetch(1'b1));

        // mfhi / mflo
        for (int i = 0; i < 2; i++) begin
            set_instr(6'b000000, (i == 0) ? 6'b010000 : 6'b010010, 1'b0);
            do_reset();
            step("mf_fetch", e_fetch(1'b1));
            step("mf_decode", e_decode(1'b0));
            step("mf_wb", e_mfwb(i == 0));
            step("mf_back", e_fetch(1'b1));
        end

        // illegal opcode and illegal R-type funct
        set_instr(6'b111111, 6'b000000, 1'b0);
        do_reset();
        step("ill_fetch", e_fetch(1'b1));
        step("ill_decode", e_decode(1'b1));
        step("ill_back", e_fetch(1'b1));
        set_instr(6'b000000, 6'b000111, 1'b0);
        do_reset();
        step("illfn_fetch", e_fetch(1'b1));
        step("illfn_decode", e_decode(1'b1));
        step("illfn_back", e_fetch(1'b1));

        // sw: normal completion, then reset while held in MEMWR
        set_instr(6'b101011, 6'b000000, 1'b0);
        do_reset();
        step("sw_fetch", e_fetch(1'b1));
        step("sw_decode", e_decode(1'b0));
        step("sw_memadr", e_memadr());
        step("sw_memwr", e_mem(1'b1));
        step("sw_back", e_fetch(1'b1));
        step("sw_decode2", e_decode(1'b0));
        step("sw_memadr2", e_memadr());
        r_mem_ready = 1'b0;
        step("sw_hold", e_mem(1'b1));
        step("sw_hold2", e_mem(1'b1));
        r_reset = 1'b1;
        #1;
        check("sw_async_reset", w_act, e_fetch(1'b0));
        @(negedge clk);
        r_reset = 1'b0;
        r_mem_ready = 1'b1;
        step("sw_after_reset", e_fetch(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
